// File: rtl/sm_tc_convert_pipe_if.sv
// sm_tc_convert_pipe_if: input/output beat handshake plus overflow counter bundle
interface sm_tc_convert_pipe_if #(
  parameter int MAG_W = 26,
  parameter int CNT_W = 8
);
  logic             in_valid;
  logic             in_ready;
  logic             in_mode;
  logic             in_sign;
  logic [MAG_W:0]   in_data;
  logic             out_valid;
  logic             out_ready;
  logic             out_mode;
  logic             out_sign;
  logic             out_ovf;
  logic [MAG_W:0]   out_data;
  logic [CNT_W-1:0] ovf_cnt;
  logic             ovf_clr;
  modport master (
    output in_valid, in_mode, in_sign, in_data, out_ready, ovf_clr,
    input  in_ready, out_valid, out_mode, out_sign, out_ovf, out_data, ovf_cnt
  );
  modport slave (
    input  in_valid, in_mode, in_sign, in_data, out_ready, ovf_clr,
    output in_ready, out_valid, out_mode, out_sign, out_ovf, out_data, ovf_cnt
  );
endinterface

// File: rtl/sm_tc_convert_pipe.sv
// sm_tc_convert_pipe: pipelined sign-magnitude <-> two's-complement converter with global stall
module sm_tc_convert_pipe #(
  parameter int MAG_W   = 26,
  parameter int LATENCY = 2,
  parameter int CNT_W   = 8
) (
  input logic               CLK,
  input logic               nRST,
  sm_tc_convert_pipe_if.slave bus
);
  localparam int PW = MAG_W + 4;
  logic [LATENCY-1:0] v;
  logic [PW-1:0]      p [LATENCY];
  logic [PW-1:0]      p0;
  logic [MAG_W:0]     tc, mag1;
  logic               adv, neg, most_neg;
  logic [CNT_W-1:0]   cnt;
  // payload packs {mode, sign, ovf, data}; arithmetic is done before stage 1
  always_comb begin
    tc       = bus.in_sign ? -{1'b0, bus.in_data[MAG_W-1:0]} : {1'b0, bus.in_data[MAG_W-1:0]};
    neg      = bus.in_data[MAG_W];
    most_neg = neg & ~|bus.in_data[MAG_W-1:0];
    mag1     = most_neg ? {1'b0, {MAG_W{1'b1}}} : (neg ? -bus.in_data : bus.in_data);
    p0       = bus.in_mode ? {1'b1, neg, most_neg, mag1} : {1'b0, tc[MAG_W], 1'b0, tc};
  end
  assign adv           = bus.out_ready | ~bus.out_valid;
  assign bus.in_ready  = adv;
  assign bus.out_valid = v[LATENCY-1];
  assign {bus.out_mode, bus.out_sign, bus.out_ovf, bus.out_data} = p[LATENCY-1];
  assign bus.ovf_cnt   = cnt;
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      v <= '0;
      for (int i = 0; i < LATENCY; i++) p[i] <= '0;
    end else if (adv) begin
      v[0] <= bus.in_valid;
      p[0] <= p0;
      for (int i = 1; i < LATENCY; i++) begin
        v[i] <= v[i-1];
        p[i] <= p[i-1];
      end
    end
  end
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) cnt <= '0;
    else if (bus.ovf_clr) cnt <= '0;
    else if (bus.out_valid & bus.out_ready & bus.out_ovf & ~&cnt) cnt <= cnt + CNT_W'(1);
  end
endmodule
